// File: rtl/cs_product_accumulator_if.sv
// Handshake bundle between the multiplier side and the product accumulator.
// The master modport drives products and result-ready; the slave (the accumulator) drives the rest.
interface cs_product_accumulator_if #(
  parameter int PROD_W = 9,
  parameter int ACC_W  = 11,
  parameter int CNT_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_overflow;
  logic [CNT_W-1:0]  beat_cnt;

  modport master (
    output in_valid,
    output in_product,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_overflow,
    input  beat_cnt
  );

  modport slave (
    input  in_valid,
    input  in_product,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_overflow,
    output beat_cnt
  );
endinterface

// File: rtl/cs_product_accumulator.sv
// Sums COUNT products per frame; result valid 1 cycle after the last accept, held until taken.
// Input is stalled (in_ready=0) while a result waits; out_sum/out_overflow stay stable meanwhile.
module cs_product_accumulator #(
  parameter int PROD_W = 9,
  parameter int COUNT  = 4,
  parameter int ACC_W  = 11,
  parameter int CNT_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  cs_product_accumulator_if.slave bus
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic               out_ovf_q, out_ovf_d;

  logic               accept;
  logic               fire;
  logic               last_beat;
  logic [ACC_W:0]     sum_ext;

  assign bus.in_ready     = (state_q == ACCUM) & ~rst;
  assign bus.out_valid    = (state_q == DONE);
  assign bus.out_sum      = out_sum_q;
  assign bus.out_overflow = out_ovf_q;
  assign bus.beat_cnt     = beat_q;

  assign accept    = bus.in_valid & bus.in_ready;
  assign fire      = bus.out_valid & bus.out_ready;
  assign last_beat = (beat_q == CNT_W'(COUNT - 1));
  // Carry out of the extra top bit is what feeds the sticky overflow flag.
  assign sum_ext   = {1'b0, acc_q} + (ACC_W + 1)'(bus.in_product);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    beat_d    = beat_q;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d  = sum_ext[ACC_W-1:0];
          ovf_d  = ovf_q | sum_ext[ACC_W];
          beat_d = beat_q + CNT_W'(1);
          if (last_beat) begin
            state_d   = DONE;
            out_sum_d = sum_ext[ACC_W-1:0];
            out_ovf_d = ovf_q | sum_ext[ACC_W];
          end
        end
      end
      DONE: begin
        if (fire) begin
          state_d = ACCUM;
          acc_d   = '0;
          ovf_d   = 1'b0;
          beat_d  = '0;
        end
      end
      default: state_d = ACCUM;
    endcase

    // Abort wins over any accept or fire in the same cycle; the last published result is kept.
    if (clr) begin
      state_d = ACCUM;
      acc_d   = '0;
      ovf_d   = 1'b0;
      beat_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      beat_q    <= '0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      beat_q    <= beat_d;
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_cs_product_accumulator.sv
// Directed bench: a vector table on the default (COUNT=4, ACC_W=11) instance plus
// hand-written sequences for reset, reset-in-DONE and the ACC_W=10/COUNT=8 overflow case.
module tb_cs_product_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, clr_a, rst_b, clr_b;

  cs_product_accumulator_if #(.PROD_W(9), .ACC_W(11), .CNT_W(3)) if_a ();
  cs_product_accumulator_if #(.PROD_W(9), .ACC_W(10), .CNT_W(4)) if_b ();

  cs_product_accumulator #(.PROD_W(9), .COUNT(4), .ACC_W(11), .CNT_W(3)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .clr (clr_a),
    .bus (if_a.slave)
  );

  cs_product_accumulator #(.PROD_W(9), .COUNT(8), .ACC_W(10), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .clr (clr_b),
    .bus (if_b.slave)
  );

  typedef struct {
    logic        v;
    logic [8:0]  p;
    logic        ordy;
    logic        clr;
    logic        ev;
    logic [10:0] esum;
    logic        eovf;
    logic [2:0]  ebeat;
    logic        erdy;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input int p, input logic ordy, input logic c,
                     input logic ev, input int esum, input logic eovf,
                     input int ebeat, input logic erdy);
    vec_t r;
    r.v = v; r.p = 9'(p); r.ordy = ordy; r.clr = c;
    r.ev = ev; r.esum = 11'(esum); r.eovf = eovf; r.ebeat = 3'(ebeat); r.erdy = erdy;
    tbl.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic ev, input int esum, input logic eovf,
                       input int ebeat, input logic erdy);
    chk({tag, ".out_valid"},    int'(if_a.out_valid),    int'(ev));
    chk({tag, ".out_sum"},      int'(if_a.out_sum),      esum);
    chk({tag, ".out_overflow"}, int'(if_a.out_overflow), int'(eovf));
    chk({tag, ".beat_cnt"},     int'(if_a.beat_cnt),     ebeat);
    chk({tag, ".in_ready"},     int'(if_a.in_ready),     int'(erdy));
  endtask

  task automatic chk_b(input string tag, input logic ev, input int esum, input logic eovf,
                       input int ebeat);
    chk({tag, ".out_valid"},    int'(if_b.out_valid),    int'(ev));
    chk({tag, ".out_sum"},      int'(if_b.out_sum),      esum);
    chk({tag, ".out_overflow"}, int'(if_b.out_overflow), int'(eovf));
    chk({tag, ".beat_cnt"},     int'(if_b.beat_cnt),     ebeat);
  endtask

  initial begin
    // Back-to-back frame, immediate drain: 12+70+126+36 = 244
    add(1,  12, 1, 0,  0,   0, 0, 1, 1);
    add(1,  70, 1, 0,  0,   0, 0, 2, 1);
    add(1, 126, 1, 0,  0,   0, 0, 3, 1);
    add(1,  36, 1, 0,  1, 244, 0, 4, 0);
    add(0,   0, 1, 0,  0, 244, 0, 0, 1);
    // Same frame, result held 5 cycles under backpressure with stray valids
    add(1,  12, 0, 0,  0, 244, 0, 1, 1);
    add(1,  70, 0, 0,  0, 244, 0, 2, 1);
    add(1, 126, 0, 0,  0, 244, 0, 3, 1);
    add(1,  36, 0, 0,  1, 244, 0, 4, 0);
    for (int i = 0; i < 5; i++) add(1, 99, 0, 0, 1, 244, 0, 4, 0);
    add(0,   0, 1, 0,  0, 244, 0, 0, 1);
    add(0,   0, 0, 0,  0, 244, 0, 0, 1);
    // Gapped input, one valid every third cycle: 4*225 = 900
    add(1, 225, 0, 0,  0, 244, 0, 1, 1);
    add(0,   0, 0, 0,  0, 244, 0, 1, 1);
    add(0,   0, 0, 0,  0, 244, 0, 1, 1);
    add(1, 225, 0, 0,  0, 244, 0, 2, 1);
    add(0,   0, 0, 0,  0, 244, 0, 2, 1);
    add(0,   0, 0, 0,  0, 244, 0, 2, 1);
    add(1, 225, 0, 0,  0, 244, 0, 3, 1);
    add(0,   0, 0, 0,  0, 244, 0, 3, 1);
    add(0,   0, 0, 0,  0, 244, 0, 3, 1);
    add(1, 225, 1, 0,  1, 900, 0, 4, 0);
    add(0,   0, 1, 0,  0, 900, 0, 0, 1);
    // Abort mid-frame, coincident accept discarded; then 3+4+5+6 = 18
    add(1,  70, 0, 0,  0, 900, 0, 1, 1);
    add(1, 126, 0, 0,  0, 900, 0, 2, 1);
    add(1,   5, 0, 1,  0, 900, 0, 0, 1);
    add(1,   3, 0, 0,  0, 900, 0, 1, 1);
    add(1,   4, 0, 0,  0, 900, 0, 2, 1);
    add(1,   5, 0, 0,  0, 900, 0, 3, 1);
    add(1,   6, 0, 0,  1,  18, 0, 4, 0);
    // Abort in DONE beats a simultaneous fire; last result kept
    add(0,   0, 1, 1,  0,  18, 0, 0, 1);
    // Frame 100+200+300+400 = 1000 parked in DONE for the reset check
    add(1, 100, 0, 0,  0,  18, 0, 1, 1);
    add(1, 200, 0, 0,  0,  18, 0, 2, 1);
    add(1, 300, 0, 0,  0,  18, 0, 3, 1);
    add(1, 400, 0, 0,  1, 1000, 0, 4, 0);

    rst_a = 1'b1; clr_a = 1'b0;
    rst_b = 1'b1; clr_b = 1'b0;
    if_a.in_valid = 1'b0; if_a.in_product = '0; if_a.out_ready = 1'b0;
    if_b.in_valid = 1'b0; if_b.in_product = '0; if_b.out_ready = 1'b0;

    for (int i = 0; i < 3; i++) step();
    chk("reset.in_ready_low", int'(if_a.in_ready), 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    chk_a("reset", 1'b0, 0, 1'b0, 0, 1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      if_a.in_valid   = tbl[i].v;
      if_a.in_product = tbl[i].p;
      if_a.out_ready  = tbl[i].ordy;
      clr_a           = tbl[i].clr;
      step();
      chk_a($sformatf("row%0d", i), tbl[i].ev, int'(tbl[i].esum), tbl[i].eovf,
            int'(tbl[i].ebeat), tbl[i].erdy);
    end

    // Reset while holding a result
    if_a.in_valid = 1'b0; if_a.out_ready = 1'b0; clr_a = 1'b0;
    rst_a = 1'b1;
    #1;
    chk("rst_in_done.in_ready_comb", int'(if_a.in_ready), 0);
    step();
    chk_a("rst_in_done", 1'b0, 0, 1'b0, 0, 1'b0);
    rst_a = 1'b0;
    #1;
    chk("rst_in_done.in_ready_after", int'(if_a.in_ready), 1);

    // Narrow accumulator: 8*225 = 1800 wraps to 776 with sticky overflow
    if_b.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if_b.in_valid = 1'b1; if_b.in_product = 9'd225;
      step();
      if (i < 7) chk($sformatf("ovf_frame.beat%0d", i), int'(if_b.beat_cnt), i + 1);
    end
    if_b.in_valid = 1'b0;
    chk_b("ovf_frame", 1'b1, 776, 1'b1, 8);
    if_b.out_ready = 1'b1;
    step();
    chk_b("ovf_fire", 1'b0, 776, 1'b1, 0);
    if_b.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if_b.in_valid = 1'b1; if_b.in_product = 9'd1;
      step();
    end
    if_b.in_valid = 1'b0;
    chk_b("ones_frame", 1'b1, 8, 1'b0, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
